// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
// Shared types and helpers for the frame sequencer slice.
//   phase_t        : per-frame phase encoding (IDLE=0, PROC=1, NORM=2, SEND=3),
//                    also driven directly onto the phase output.
//   most_neg_score : most-negative two's-complement value for a given width,
//                    used as the "no score yet" value of the running maximum.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    NORM = 2'd2,
    SEND = 2'd3
  } phase_t;

  // Returned as 64 bits; callers size it down to their score width.
  function automatic logic [63:0] most_neg_score(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/frame_seq_max.sv
// frame_seq_max
// Streaming signed maximum with the index of the winning sample.
// Strictly-greater replaces, so on a tie the earlier index is kept.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_clear         : restart the search (best = most-negative, idx = 0)
//   i_valid         : i_idx / i_score carry a new sample this cycle
//   i_idx, i_score  : sample index and signed score
//   o_best_score    : running maximum (most-negative when empty)
//   o_best_idx      : index of the running maximum
module frame_seq_max
  import frame_seq_pkg::*;
#(
  parameter int IDX_W   = 8,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [SCORE_W-1:0] i_score,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [IDX_W-1:0]   o_best_idx
);

  localparam logic [SCORE_W-1:0] L_MOST_NEG = SCORE_W'(most_neg_score(SCORE_W));

  logic [SCORE_W-1:0] r_best_score;
  logic [IDX_W-1:0]   r_best_idx;
  logic               w_better;

  assign w_better = $signed(i_score) > $signed(r_best_score);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_best_score <= L_MOST_NEG;
      r_best_idx   <= '0;
    end else if (i_clear) begin
      r_best_score <= L_MOST_NEG;
      r_best_idx   <= '0;
    end else if (i_valid && w_better) begin
      r_best_score <= i_score;
      r_best_idx   <= i_idx;
    end
  end

  assign o_best_score = r_best_score;
  assign o_best_idx   = r_best_idx;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Per-frame controller for the senone scoring datapath. Walks
// IDLE -> PROC -> NORM -> SEND, owns the single SRAM port on behalf of the
// scorer / normaliser / sender, tracks the best score of the frame, queues
// one extra frame, counts dropped vectors and guards each phase with a
// watchdog.
// Optional build macro: FRAME_SEQ_LED_EN adds o_status_led and a 26-bit
// free-running blink counter.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   i_vec_avail                : pulse, new feature vector received
//   i_score_valid/idx/data     : scorer strobe, senone index, signed score
//   i_last_senone              : qualifies the final score of the frame
//   i_norm_done, i_send_done   : phase-complete pulses
//   i_norm_rd/wr/addr/wdata    : normaliser SRAM request
//   i_send_rd/addr             : sender SRAM request
//   i_clear_err                : clears the sticky watchdog flag
//   o_start_proc/norm/send     : high during the first cycle of each phase
//   o_phase                    : current phase (IDLE=0 PROC=1 NORM=2 SEND=3)
//   o_sram_rd/wr/addr/wdata    : arbitrated SRAM port
//   o_best_score/idx/valid     : frame maximum, valid from first NORM cycle
//   o_overrun_cnt              : saturating count of dropped vectors
//   o_wdog_err                 : sticky watchdog flag
//   o_status_led               : (FRAME_SEQ_LED_EN only) status indicator
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int N_SENONES  = 3,
  parameter int IDX_W      = 8,
  parameter int SCORE_W    = 16,
  parameter int ADDR_W     = 21,
  parameter int ADDR_SHIFT = 1,
  parameter int WDOG_W     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_vec_avail,
  input  logic               i_score_valid,
  input  logic [IDX_W-1:0]   i_score_idx,
  input  logic [SCORE_W-1:0] i_score_data,
  input  logic               i_last_senone,
  input  logic               i_norm_done,
  input  logic               i_send_done,
  input  logic               i_norm_rd,
  input  logic               i_norm_wr,
  input  logic [ADDR_W-1:0]  i_norm_addr,
  input  logic [SCORE_W-1:0] i_norm_wdata,
  input  logic               i_send_rd,
  input  logic [ADDR_W-1:0]  i_send_addr,
  input  logic               i_clear_err,
  output logic               o_start_proc,
  output logic               o_start_norm,
  output logic               o_start_send,
  output logic [1:0]         o_phase,
  output logic               o_sram_rd,
  output logic               o_sram_wr,
  output logic [ADDR_W-1:0]  o_sram_addr,
  output logic [SCORE_W-1:0] o_sram_wdata,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [IDX_W-1:0]   o_best_idx,
  output logic               o_best_valid,
  output logic [7:0]         o_overrun_cnt,
`ifdef FRAME_SEQ_LED_EN
  output logic               o_wdog_err,
  output logic               o_status_led
`else
  output logic               o_wdog_err
`endif
);

  // A frame's senone indices must be addressable with IDX_W bits.
  if (N_SENONES < 1 || N_SENONES > (2 ** IDX_W)) begin : g_bad_cfg
    $error("frame_sequencer: N_SENONES does not fit in IDX_W bits");
  end

  // Expiry is the counter reaching all-ones; we act on the edge that would
  // load all-ones, so a phase lasts at most 2**WDOG_W - 1 cycles.
  localparam logic [WDOG_W-1:0] L_WDOG_LAST = ~WDOG_W'(1);

  phase_t            r_state;
  phase_t            w_state_next;
  logic              r_start_proc;
  logic              r_start_norm;
  logic              r_start_send;
  logic              r_pending;
  logic [7:0]        r_overrun_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_wdog_err;
  logic              r_best_valid;

  logic              w_wdog_fire;
  logic              w_enter_proc;
  logic              w_enter_norm;
  logic              w_state_change;
  logic              w_score_in_proc;

  assign w_wdog_fire     = (r_state != IDLE) && (r_wdog == L_WDOG_LAST);
  assign w_state_change  = (w_state_next != r_state);
  assign w_enter_proc    = (r_state == IDLE) && (w_state_next == PROC);
  assign w_enter_norm    = (r_state == PROC) && (w_state_next == NORM);
  assign w_score_in_proc = (r_state == PROC) && i_score_valid;

  // ---------------------------------------------------------------------
  // FSM: state register (start pulses are registered alongside the state
  // so each one is high exactly in the first cycle of its phase)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_start_proc <= 1'b0;
      r_start_norm <= 1'b0;
      r_start_send <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_start_proc <= w_state_change && (w_state_next == PROC);
      r_start_norm <= w_state_change && (w_state_next == NORM);
      r_start_send <= w_state_change && (w_state_next == SEND);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic (watchdog overrides every normal transition)
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (i_vec_avail || r_pending)        w_state_next = PROC;
      PROC: if (i_score_valid && i_last_senone)  w_state_next = NORM;
      NORM: if (i_norm_done)                     w_state_next = SEND;
      SEND: if (i_send_done)                     w_state_next = IDLE;
      default:                                   w_state_next = IDLE;
    endcase
    if (w_wdog_fire) begin
      w_state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (SRAM mux is purely a function of the registered phase)
  // ---------------------------------------------------------------------
  always_comb begin
    o_sram_rd    = 1'b0;
    o_sram_wr    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    unique case (r_state)
      PROC: begin
        o_sram_wr    = i_score_valid;
        o_sram_addr  = ADDR_W'(i_score_idx) << ADDR_SHIFT;
        o_sram_wdata = i_score_data;
      end
      NORM: begin
        o_sram_rd    = i_norm_rd;
        o_sram_wr    = i_norm_wr;
        o_sram_addr  = i_norm_addr;
        o_sram_wdata = i_norm_wdata;
      end
      SEND: begin
        o_sram_rd    = i_send_rd;
        o_sram_addr  = i_send_addr;
      end
      default: begin
        o_sram_rd    = 1'b0;
      end
    endcase
  end

  assign o_phase      = r_state;
  assign o_start_proc = r_start_proc;
  assign o_start_norm = r_start_norm;
  assign o_start_send = r_start_send;

  // ---------------------------------------------------------------------
  // Frame queueing, overrun count, watchdog, best_valid
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending     <= 1'b0;
      r_overrun_cnt <= '0;
      r_wdog        <= '0;
      r_wdog_err    <= 1'b0;
      r_best_valid  <= 1'b0;
    end else begin
      // Entering PROC consumes the queued frame; a vector arriving on that
      // same edge while one was queued becomes the new queued frame. In IDLE
      // without a queued frame the vector itself starts the frame.
      if (w_enter_proc) begin
        r_pending <= r_pending && i_vec_avail;
      end else if ((r_state != IDLE) && i_vec_avail) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_overrun_cnt != 8'hFF) begin
          r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
      end

      if (w_state_change || (r_state == IDLE)) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end

      // Set has priority over clear.
      if (w_wdog_fire) begin
        r_wdog_err <= 1'b1;
      end else if (i_clear_err) begin
        r_wdog_err <= 1'b0;
      end

      if (w_enter_proc) begin
        r_best_valid <= 1'b0;
      end else if (w_enter_norm) begin
        r_best_valid <= 1'b1;
      end
    end
  end

  assign o_overrun_cnt = r_overrun_cnt;
  assign o_wdog_err    = r_wdog_err;
  assign o_best_valid  = r_best_valid;

  // ---------------------------------------------------------------------
  // Running maximum; only scores seen in PROC count
  // ---------------------------------------------------------------------
  frame_seq_max #(
    .IDX_W   (IDX_W),
    .SCORE_W (SCORE_W)
  ) u_max (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_enter_proc),
    .i_valid      (w_score_in_proc),
    .i_idx        (i_score_idx),
    .i_score      (i_score_data),
    .o_best_score (o_best_score),
    .o_best_idx   (o_best_idx)
  );

`ifdef FRAME_SEQ_LED_EN
  // Blink rate gets faster as the frame advances; solid on when idle.
  logic [25:0] r_led_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led_cnt <= '0;
    end else begin
      r_led_cnt <= r_led_cnt + 26'd1;
    end
  end

  always_comb begin
    o_status_led = 1'b0;
    unique case (r_state)
      IDLE:    o_status_led = 1'b1;
      PROC:    o_status_led = r_led_cnt[25];
      NORM:    o_status_led = r_led_cnt[24];
      SEND:    o_status_led = r_led_cnt[23];
      default: o_status_led = 1'b0;
    endcase
    if (r_wdog_err) begin
      o_status_led = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
// Directed checks of frame_sequencer: reset values, a nominal frame with
// SRAM write addresses and best-score tracking, SRAM arbitration per phase,
// frame queueing and overrun counting, overrun saturation, watchdog expiry
// with WDOG_W=4, and asynchronous reset in the middle of PROC.
// Inputs change on the falling edge; the DUT samples on the rising edge.
module tb_frame_sequencer;

  localparam int IDX_W   = 8;
  localparam int SCORE_W = 16;
  localparam int ADDR_W  = 21;

  logic               clk;
  logic               reset;
  logic               vec_avail;
  logic               score_valid;
  logic [IDX_W-1:0]   score_idx;
  logic [SCORE_W-1:0] score_data;
  logic               last_senone;
  logic               norm_done;
  logic               send_done;
  logic               norm_rd;
  logic               norm_wr;
  logic [ADDR_W-1:0]  norm_addr;
  logic [SCORE_W-1:0] norm_wdata;
  logic               send_rd;
  logic [ADDR_W-1:0]  send_addr;
  logic               clear_err;
  logic               start_proc;
  logic               start_norm;
  logic               start_send;
  logic [1:0]         phase;
  logic               sram_rd;
  logic               sram_wr;
  logic [ADDR_W-1:0]  sram_addr;
  logic [SCORE_W-1:0] sram_wdata;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   best_idx;
  logic               best_valid;
  logic [7:0]         overrun_cnt;
  logic               wdog_err;
`ifdef FRAME_SEQ_LED_EN
  logic               status_led;
`endif

  int total;
  int bad;

  frame_sequencer #(
    .N_SENONES  (3),
    .IDX_W      (IDX_W),
    .SCORE_W    (SCORE_W),
    .ADDR_W     (ADDR_W),
    .ADDR_SHIFT (1),
    .WDOG_W     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_vec_avail   (vec_avail),
    .i_score_valid (score_valid),
    .i_score_idx   (score_idx),
    .i_score_data  (score_data),
    .i_last_senone (last_senone),
    .i_norm_done   (norm_done),
    .i_send_done   (send_done),
    .i_norm_rd     (norm_rd),
    .i_norm_wr     (norm_wr),
    .i_norm_addr   (norm_addr),
    .i_norm_wdata  (norm_wdata),
    .i_send_rd     (send_rd),
    .i_send_addr   (send_addr),
    .i_clear_err   (clear_err),
    .o_start_proc  (start_proc),
    .o_start_norm  (start_norm),
    .o_start_send  (start_send),
    .o_phase       (phase),
    .o_sram_rd     (sram_rd),
    .o_sram_wr     (sram_wr),
    .o_sram_addr   (sram_addr),
    .o_sram_wdata  (sram_wdata),
    .o_best_score  (best_score),
    .o_best_idx    (best_idx),
    .o_best_valid  (best_valid),
    .o_overrun_cnt (overrun_cnt),
`ifdef FRAME_SEQ_LED_EN
    .o_wdog_err    (wdog_err),
    .o_status_led  (status_led)
`else
    .o_wdog_err    (wdog_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one full clock; returns on the falling edge after the rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    vec_avail = 0; score_valid = 0; score_idx = '0; score_data = '0;
    last_senone = 0; norm_done = 0; send_done = 0; norm_rd = 0; norm_wr = 0;
    norm_addr = '0; norm_wdata = '0; send_rd = 0; send_addr = '0; clear_err = 0;

    // ---------------- reset state ----------------
    #2;
    check("rst_phase",      32'(phase), 0);
    check("rst_best_score", 32'(best_score), 32'h8000);
    check("rst_best_idx",   32'(best_idx), 0);
    check("rst_outputs",    32'({start_proc, start_norm, start_send, sram_rd, sram_wr, best_valid, wdog_err}), 0);
    check("rst_overrun",    32'(overrun_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("idle_hold", 32'(phase), 0);

    // ---------------- nominal frame ----------------
    vec_avail = 1; cyc(); vec_avail = 0;
    check("nom_phase_proc", 32'(phase), 1);
    check("nom_start_proc", 32'(start_proc), 1);
    score_valid = 1; score_idx = 8'd0; score_data = 16'hFFF0; #1;
    check("nom_wr0",    32'(sram_wr), 1);
    check("nom_addr0",  32'(sram_addr), 0);
    check("nom_wdata0", 32'(sram_wdata), 32'hFFF0);
    cyc();
    check("nom_start_proc_off", 32'(start_proc), 0);
    check("nom_best_after0", 32'(best_score), 32'hFFF0);
    score_idx = 8'd1; score_data = 16'h0010; #1;
    check("nom_addr1", 32'(sram_addr), 2);
    cyc();
    score_idx = 8'd2; score_data = 16'h0010; last_senone = 1; #1;
    check("nom_addr2", 32'(sram_addr), 4);
    cyc();
    score_valid = 0; last_senone = 0;
    check("nom_phase_norm", 32'(phase), 2);
    check("nom_start_norm", 32'(start_norm), 1);
    check("nom_best_score", 32'(best_score), 32'h0010);
    check("nom_best_idx",   32'(best_idx), 1);
    check("nom_best_valid", 32'(best_valid), 1);

    // arbitration: normaliser owns the port in NORM
    norm_wr = 1; norm_addr = 21'h1A; norm_wdata = 16'h1234; #1;
    check("arb_norm_wr",    32'(sram_wr), 1);
    check("arb_norm_addr",  32'(sram_addr), 32'h1A);
    check("arb_norm_wdata", 32'(sram_wdata), 32'h1234);
    cyc();
    check("nom_start_norm_off", 32'(start_norm), 0);
    norm_done = 1; cyc(); norm_done = 0;
    check("nom_phase_send", 32'(phase), 3);
    check("nom_start_send", 32'(start_send), 1);
    #1;
    check("arb_send_no_wr",   32'(sram_wr), 0);
    check("arb_send_no_addr", 32'(sram_addr), 0);
    send_rd = 1; send_addr = 21'h44; norm_wr = 0; #1;
    check("arb_send_rd",   32'(sram_rd), 1);
    check("arb_send_addr", 32'(sram_addr), 32'h44);
    send_done = 1; cyc(); send_done = 0; send_rd = 0; send_addr = '0;
    check("nom_phase_idle", 32'(phase), 0);
    check("nom_best_valid_held", 32'(best_valid), 1);

    // stray score in IDLE: no write, no max update
    score_valid = 1; score_idx = 8'd5; score_data = 16'h7000; #1;
    check("stray_no_wr", 32'(sram_wr), 0);
    cyc(); score_valid = 0;
    check("stray_best", 32'(best_score), 32'h0010);
    check("stray_idle", 32'(phase), 0);

    // ---------------- queueing ----------------
    vec_avail = 1; cyc();                         // frame A starts
    check("q_phase_proc", 32'(phase), 1);
    cyc(); vec_avail = 0;                         // second pulse -> pending
    check("q_no_overrun", 32'(overrun_cnt), 0);
    score_valid = 1; last_senone = 1; score_idx = 8'd0; score_data = 16'h0005;
    cyc(); score_valid = 0; last_senone = 0;
    check("q_phase_norm", 32'(phase), 2);
    check("q_best", 32'(best_score), 32'h0005);
    vec_avail = 1; cyc(); vec_avail = 0;         // third pulse -> dropped
    check("q_overrun_1", 32'(overrun_cnt), 1);
    norm_done = 1; cyc(); norm_done = 0;
    send_done = 1; cyc(); send_done = 0;
    check("q_back_idle", 32'(phase), 0);
    check("q_idle_no_start", 32'(start_proc), 0);
    cyc();
    check("q_second_proc", 32'(phase), 1);
    check("q_second_start", 32'(start_proc), 1);
    check("q_best_cleared", 32'(best_score), 32'h8000);
    check("q_best_valid_cleared", 32'(best_valid), 0);

    // ---------------- watchdog ----------------
    score_valid = 1; last_senone = 1; score_idx = 8'd0; score_data = 16'h0001;
    cyc(); score_valid = 0; last_senone = 0;
    check("wd_in_norm", 32'(phase), 2);
    for (int i = 0; i < 14; i++) cyc();
    check("wd_still_norm", 32'(phase), 2);
    check("wd_no_err_yet", 32'(wdog_err), 0);
    cyc();
    check("wd_forced_idle", 32'(phase), 0);
    check("wd_err_set", 32'(wdog_err), 1);
    cyc();
    check("wd_err_sticky", 32'(wdog_err), 1);
    clear_err = 1; cyc(); clear_err = 0;
    check("wd_err_cleared", 32'(wdog_err), 0);

    // ---------------- overrun saturation ----------------
    vec_avail = 1; cyc(); vec_avail = 0;
    score_valid = 1; last_senone = 1; cyc(); score_valid = 0; last_senone = 0;
    norm_done = 1; cyc(); norm_done = 0;
    check("sat_in_send", 32'(phase), 3);
    vec_avail = 1;
    for (int i = 0; i < 300; i++) cyc();
    vec_avail = 0;
    check("sat_overrun_255", 32'(overrun_cnt), 255);

    // ---------------- async reset mid-PROC ----------------
    #2 reset = 1; #1;
    check("ar1_overrun", 32'(overrun_cnt), 0);
    check("ar1_wdog", 32'(wdog_err), 0);
    @(negedge clk); reset = 0;
    vec_avail = 1; cyc(); vec_avail = 0;
    score_valid = 1; score_idx = 8'd1; score_data = 16'h0100; cyc();
    check("ar_proc", 32'(phase), 1);
    check("ar_best_pre", 32'(best_score), 32'h0100);
    #2 reset = 1; #1;                           // well before the next rising edge
    check("ar_phase",      32'(phase), 0);
    check("ar_best_score", 32'(best_score), 32'h8000);
    check("ar_best_idx",   32'(best_idx), 0);
    check("ar_sram_wr",    32'(sram_wr), 0);
    check("ar_flags",      32'({start_proc, start_norm, start_send, best_valid, overrun_cnt, wdog_err}), 0);
    score_valid = 0;
    @(negedge clk); reset = 0;
    cyc();
    check("ar_idle_after", 32'(phase), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Parametrised per-frame controller for the senone scoring datapath. Sequences IDLE→PROC→NORM→SEND, arbitrates the single SRAM port among scorer/normaliser/sender, and tracks the best score inline.
- Adds one-deep frame queueing, overrun counting and a phase watchdog.
- Sits between the UART/GDP front end and the sram, normaliser and send units.

Parameters:
- N_SENONES, 3, senones per frame
- IDX_W, 8, senone index width
- SCORE_W, 16, signed score width
- ADDR_W, 21, SRAM address width
- ADDR_SHIFT, 1, log2 bytes per stored score; write address = idx << ADDR_SHIFT
- WDOG_W, 20, watchdog counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- vec_avail  in  1  one-cycle pulse: new feature vector received
- score_valid  in  1  scorer score strobe
- score_idx  in  IDX_W  senone index of score_data
- score_data  in  SCORE_W  signed score
- last_senone  in  1  final score of frame
- norm_done, send_done  in  1  phase-complete pulses
- norm_rd, norm_wr  in  1  normaliser SRAM requests
- norm_addr  in  ADDR_W; norm_wdata  in  SCORE_W
- send_rd  in  1; send_addr  in  ADDR_W  sender SRAM requests
- clear_err  in  1  clears sticky wdog_err
- start_proc, start_norm, start_send  out  1  phase-start pulses
- phase  out  2  IDLE=0, PROC=1, NORM=2, SEND=3
- sram_rd, sram_wr  out  1; sram_addr  out  ADDR_W; sram_wdata  out  SCORE_W
- best_score  out  SCORE_W; best_idx  out  IDX_W; best_valid  out  1
- overrun_cnt  out  8  saturating count of dropped vectors
- wdog_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE. All outputs 0, except best_score = most-negative value. pending = 0, watchdog = 0. Reset mid-frame aborts immediately.
- Transitions take effect on the next edge:
  - IDLE→PROC on vec_avail or pending.
  - PROC→NORM on score_valid && last_senone.
  - NORM→SEND on norm_done.
  - SEND→IDLE on send_done.
- start_X is registered and high exactly during the first cycle of phase X.
- Entering PROC:
  - Clears pending and best_valid.
  - Loads best_score = most-negative value and best_idx = 0.
  - If vec_avail arrives in the same cycle that pending is consumed, pending is set again.
- vec_avail outside IDLE:
  - pending = 0 → pending = 1.
  - pending = 1 → overrun_cnt += 1, saturating at 255.
- PROC, on score_valid: signed compare. Strictly greater replaces best_score/best_idx, so ties keep the earlier index. best_valid is set in the first NORM cycle and held until the next PROC entry.
- score_valid outside PROC is ignored: no SRAM write, no max update.
- SRAM mux is combinational from the registered state; inactive outputs drive 0, never Z.
  - PROC: sram_wr = score_valid, sram_rd = 0, sram_addr = zero-extended score_idx << ADDR_SHIFT, sram_wdata = score_data.
  - NORM: norm_* passed through.
  - SEND: sram_rd = send_rd, sram_addr = send_addr, sram_wr = 0, sram_wdata = 0.
  - IDLE: all 0.
- Watchdog:
  - Counter clears on every state change and counts while not IDLE.
  - When it reaches all-ones: force IDLE, set wdog_err, keep pending (a queued frame starts next cycle).
  - wdog_err clears only on clear_err or reset. If a set and clear_err coincide, set wins.
- norm_done/send_done outside their own phase are ignored.

Optional Feature:
- FRAME_SEQ_LED_EN defined:
  - Adds output status_led (1) and a 26-bit free-running counter.
  - status_led = 1 in IDLE; counter bit 25/24/23 in PROC/NORM/SEND; forced 0 while wdog_err.
- Undefined: no port, no counter; all other behaviour is identical.

Decomposition:
- Package frame_seq_pkg: phase_t enum (IDLE, PROC, NORM, SEND; 2-bit encoded) and the most-negative-score constant function.
- Sub-module frame_seq_max (streaming signed max with index, per-frame clear). The SRAM mux stays inline.

Test Plan:
- Nominal frame: vec_avail; scores idx0=0xFFF0, idx1=0x0010, idx2=0x0010 (last) → writes at addrs 0,2,4; start_norm one cycle later; best_score=0x0010, best_idx=1; start_send after norm_done; IDLE after send_done.
- Queueing: two vec_avail pulses and a third during NORM → pending set, overrun_cnt=1; second frame's start_proc is the cycle after send_done returns to IDLE.
- Overrun saturation: 300 vec_avail pulses during SEND → overrun_cnt=255.
- Watchdog: WDOG_W=4, hold in NORM with no norm_done → IDLE after 15 cycles, wdog_err=1; clear_err → 0.
- Arbitration: norm_wr with addr 0x1A in NORM drives sram; the same request in SEND does not; stray score_valid in IDLE → sram_wr stays 0.
- Async reset mid-PROC → all outputs 0 and best_score=0x8000 immediately, before the next clock edge.
